// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a valid/ready stream.
// Two-entry holding buffer hides the FIFO's one-cycle read latency.
//
// Ports:
//   clk_i            read-domain clock
//   rst_i            asynchronous active-low reset
//   fifo_empty_i     FIFO empty flag
//   fifo_rdata_i     FIFO read data, valid the cycle after a read
//   fifo_rd_error_i  FIFO read-error pulse
//   fifo_rd_en_o     FIFO read enable
//   m_valid_o        stream word valid
//   m_data_o         stream word
//   m_ready_i        downstream ready
//   err_o            sticky read-error flag
//   count_o          delivered-word count (only with FIFO_RD_STATS_EN)
//
// Optional feature macro: FIFO_RD_STATS_EN adds the 16-bit count_o port.

module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_rd_error_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             err_o
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      count_o
`endif
);

    logic [WIDTH-1:0] hold_q [2];
    logic             head_q;
    logic             tail_q;
    logic [1:0]       occ_q;
    logic             inflight_q;
    logic             err_q;

    logic             pop;
    logic [2:0]       level;

    assign pop = m_valid_o && m_ready_i;

    // Occupancy after this edge, counting the word now on fifo_rdata_i.
    // pop implies occ_q != 0, so this never underflows.
    assign level = {1'b0, occ_q}
                 + {2'b00, inflight_q}
                 - {2'b00, pop};

    // Gated by rst_i so the enable reads 0 while reset is held.
    assign fifo_rd_en_o = rst_i
                       && !fifo_empty_i
                       && (level < 3'd2);

    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = hold_q[head_q];
    assign err_o     = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_q[0]  <= '0;
            hold_q[1]  <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en_o;
            if (inflight_q) begin
                hold_q[tail_q] <= fifo_rdata_i;
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            occ_q <= level[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (fifo_rd_error_i) begin
            err_q <= 1'b1;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= 16'd0;
        end else if (pop) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign count_o = count_q;
`endif

endmodule
